// File: rtl/match_ctrl_if.sv
// Player-facing bus of the match controller: key/hit inputs plus score and state outputs.
// The controller attaches through the slave modport; the stimulus side uses master.
interface match_ctrl_if #(
   parameter int unsigned NUM_PLAYERS = 2,
   parameter int unsigned SCORE_BITS  = 6,
   parameter int unsigned MENU_ITEMS  = 2
);
   localparam int unsigned WIN_W = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
   localparam int unsigned SEL_W = (MENU_ITEMS  > 2) ? $clog2(MENU_ITEMS)  : 1;

   logic                              start_i;
   logic                              sel_up_i;
   logic                              sel_down_i;
   logic [NUM_PLAYERS-1:0]            hit_i;
   logic [NUM_PLAYERS*SCORE_BITS-1:0] score_o;
   logic [NUM_PLAYERS-1:0]            alive_o;
   logic [WIN_W-1:0]                  winner_o;
   logic [SEL_W-1:0]                  menu_sel_o;
   logic                              is_menu_o;
   logic                              is_playing_o;
   logic                              is_continue_o;
   logic                              is_final_o;
   logic                              round_reset_o;

   modport slave (
      input  start_i, sel_up_i, sel_down_i, hit_i,
      output score_o, alive_o, winner_o, menu_sel_o,
             is_menu_o, is_playing_o, is_continue_o, is_final_o, round_reset_o
   );

   modport master (
      output start_i, sel_up_i, sel_down_i, hit_i,
      input  score_o, alive_o, winner_o, menu_sel_o,
             is_menu_o, is_playing_o, is_continue_o, is_final_o, round_reset_o
   );
endinterface

// File: rtl/match_ctrl.sv
// Tank-game match controller: menu target selection, round scoring by last survivor,
// timed continue pause and final-winner screen. All outputs come straight from flops.
module match_ctrl #(
   parameter int unsigned NUM_PLAYERS  = 2,
   parameter int unsigned SCORE_BITS   = 6,
   parameter int unsigned WIN_SCORE    = 5,
   parameter int unsigned MENU_ITEMS   = 2,
   parameter int unsigned PAUSE_CYCLES = 64
) (
   input  logic         clk_i,
   input  logic         reset_i,
   match_ctrl_if.slave  bus
);
   localparam int unsigned WIN_W = (NUM_PLAYERS  > 2) ? $clog2(NUM_PLAYERS)  : 1;
   localparam int unsigned SEL_W = (MENU_ITEMS   > 2) ? $clog2(MENU_ITEMS)   : 1;
   localparam int unsigned CNT_W = (PAUSE_CYCLES > 2) ? $clog2(PAUSE_CYCLES) : 1;

   localparam logic [SEL_W-1:0]      SEL_LAST   = SEL_W'(MENU_ITEMS - 1);
   localparam logic [CNT_W-1:0]      PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);
   localparam logic [SCORE_BITS-1:0] SCORE_MAX  = '1;

   // One-hot encoding so each state bit is directly a registered status flag.
   typedef enum logic [3:0] {
      ST_MENU     = 4'b0001,
      ST_PLAYING  = 4'b0010,
      ST_CONTINUE = 4'b0100,
      ST_FINAL    = 4'b1000
   } state_e;

   state_e                                 state_q, state_d;
   logic [NUM_PLAYERS-1:0][SCORE_BITS-1:0] score_q, score_d;
   logic [NUM_PLAYERS-1:0]                 alive_q, alive_d;
   logic [WIN_W-1:0]                       winner_q, winner_d;
   logic [SEL_W-1:0]                       menu_sel_q, menu_sel_d;
   logic [SCORE_BITS-1:0]                  target_q, target_d;
   logic [CNT_W-1:0]                       pause_q, pause_d;
   logic                                   round_reset_q, round_reset_d;
   logic                                   start_prev_q, start_prev_d;
   logic                                   up_prev_q, up_prev_d;
   logic                                   down_prev_q, down_prev_d;
   logic [NUM_PLAYERS-1:0]                 hit_prev_q, hit_prev_d;

   logic                   start_e, up_e, down_e;
   logic [NUM_PLAYERS-1:0] hit_e, alive_nxt;
   logic                   any_alive, multi_alive;
   logic [WIN_W-1:0]       surv_idx;
   logic [SCORE_BITS-1:0]  score_new;

   // Next-state and datapath update.
   always_comb begin
      state_d       = state_q;
      score_d       = score_q;
      alive_d       = alive_q;
      winner_d      = winner_q;
      menu_sel_d    = menu_sel_q;
      target_d      = target_q;
      pause_d       = pause_q;
      round_reset_d = 1'b0;
      start_prev_d  = bus.start_i;
      up_prev_d     = bus.sel_up_i;
      down_prev_d   = bus.sel_down_i;
      hit_prev_d    = bus.hit_i;

      start_e   = bus.start_i    & ~start_prev_q;
      up_e      = bus.sel_up_i   & ~up_prev_q;
      down_e    = bus.sel_down_i & ~down_prev_q;
      hit_e     = bus.hit_i      & ~hit_prev_q;
      alive_nxt = alive_q & ~hit_e;

      // Locate the survivor and detect whether more than one remains.
      any_alive   = 1'b0;
      multi_alive = 1'b0;
      surv_idx    = '0;
      for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
         if (alive_nxt[k]) begin
            if (any_alive) multi_alive = 1'b1;
            any_alive = 1'b1;
            surv_idx  = WIN_W'(k);
         end
      end
      score_new = (score_q[surv_idx] == SCORE_MAX) ? SCORE_MAX
                                                   : score_q[surv_idx] + SCORE_BITS'(1);

      case (state_q)
         ST_MENU: begin
            if (down_e && !up_e) begin
               menu_sel_d = (menu_sel_q == SEL_LAST) ? '0 : menu_sel_q + SEL_W'(1);
            end else if (up_e && !down_e) begin
               menu_sel_d = (menu_sel_q == '0) ? SEL_LAST : menu_sel_q - SEL_W'(1);
            end
            if (start_e) begin
               target_d      = SCORE_BITS'(WIN_SCORE) *
                               (SCORE_BITS'(menu_sel_q) + SCORE_BITS'(1));
               score_d       = '0;
               alive_d       = '1;
               round_reset_d = 1'b1;
               state_d       = ST_PLAYING;
            end
         end
         ST_PLAYING: begin
            alive_d = alive_nxt;
            if (!multi_alive) begin
               if (any_alive) score_d[surv_idx] = score_new;
               if (any_alive && (score_new >= target_q)) begin
                  winner_d = surv_idx;
                  state_d  = ST_FINAL;
               end else begin
                  pause_d = '0;
                  state_d = ST_CONTINUE;
               end
            end
         end
         ST_CONTINUE: begin
            if (start_e || (pause_q == PAUSE_LAST)) begin
               alive_d       = '1;
               round_reset_d = 1'b1;
               state_d       = ST_PLAYING;
            end else begin
               pause_d = pause_q + CNT_W'(1);
            end
         end
         ST_FINAL: begin
            if (start_e) state_d = ST_MENU;
         end
         default: state_d = ST_MENU;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q       <= ST_MENU;
         score_q       <= '0;
         alive_q       <= '1;
         winner_q      <= '0;
         menu_sel_q    <= '0;
         target_q      <= SCORE_BITS'(WIN_SCORE);
         pause_q       <= '0;
         round_reset_q <= 1'b0;
         start_prev_q  <= 1'b0;
         up_prev_q     <= 1'b0;
         down_prev_q   <= 1'b0;
         hit_prev_q    <= '0;
      end else begin
         state_q       <= state_d;
         score_q       <= score_d;
         alive_q       <= alive_d;
         winner_q      <= winner_d;
         menu_sel_q    <= menu_sel_d;
         target_q      <= target_d;
         pause_q       <= pause_d;
         round_reset_q <= round_reset_d;
         start_prev_q  <= start_prev_d;
         up_prev_q     <= up_prev_d;
         down_prev_q   <= down_prev_d;
         hit_prev_q    <= hit_prev_d;
      end
   end

   assign bus.score_o       = score_q;
   assign bus.alive_o       = alive_q;
   assign bus.winner_o      = winner_q;
   assign bus.menu_sel_o    = menu_sel_q;
   assign bus.is_menu_o     = state_q[0];
   assign bus.is_playing_o  = state_q[1];
   assign bus.is_continue_o = state_q[2];
   assign bus.is_final_o    = state_q[3];
   assign bus.round_reset_o = round_reset_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl: a 2-player instance (64-cycle pause) and a
// 4-player instance (4-cycle pause) sharing clock and reset.
module tb_match_ctrl;
   logic clk_i = 1'b0;
   logic reset_i;
   int   checks = 0;
   int   errors = 0;

   localparam logic [3:0] F_MENU = 4'b0001;
   localparam logic [3:0] F_PLAY = 4'b0010;
   localparam logic [3:0] F_CONT = 4'b0100;
   localparam logic [3:0] F_FIN  = 4'b1000;

   match_ctrl_if #(.NUM_PLAYERS(2), .SCORE_BITS(6), .MENU_ITEMS(2)) bus_a ();
   match_ctrl_if #(.NUM_PLAYERS(4), .SCORE_BITS(6), .MENU_ITEMS(2)) bus_b ();

   match_ctrl #(.NUM_PLAYERS(2), .SCORE_BITS(6), .WIN_SCORE(5), .MENU_ITEMS(2),
                .PAUSE_CYCLES(64)) u_a (.clk_i(clk_i), .reset_i(reset_i), .bus(bus_a));
   match_ctrl #(.NUM_PLAYERS(4), .SCORE_BITS(6), .WIN_SCORE(5), .MENU_ITEMS(2),
                .PAUSE_CYCLES(4))  u_b (.clk_i(clk_i), .reset_i(reset_i), .bus(bus_b));

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] flags_a();
      return {bus_a.is_final_o, bus_a.is_continue_o, bus_a.is_playing_o, bus_a.is_menu_o};
   endfunction

   function automatic logic [3:0] flags_b();
      return {bus_b.is_final_o, bus_b.is_continue_o, bus_b.is_playing_o, bus_b.is_menu_o};
   endfunction

   // Start edge that skips the rest of a continue pause, then release.
   task automatic skip_pause();
      bus_a.start_i = 1'b1;
      tick();
      bus_a.start_i = 1'b0;
      tick();
   endtask

   task automatic hit_a(input logic [1:0] h);
      bus_a.hit_i = h;
      tick();
      bus_a.hit_i = '0;
   endtask

   initial begin
      reset_i = 1'b0;
      bus_a.start_i = 0; bus_a.sel_up_i = 0; bus_a.sel_down_i = 0; bus_a.hit_i = '0;
      bus_b.start_i = 0; bus_b.sel_up_i = 0; bus_b.sel_down_i = 0; bus_b.hit_i = '0;
      tick();
      tick();
      chk("rst_flags",    32'(flags_a()), 32'(F_MENU));
      chk("rst_score",    32'(bus_a.score_o), 32'h0);
      chk("rst_alive",    32'(bus_a.alive_o), 32'h3);
      chk("rst_sel",      32'(bus_a.menu_sel_o), 32'h0);
      chk("rst_rr",       32'(bus_a.round_reset_o), 32'h0);
      chk("rst_winner",   32'(bus_a.winner_o), 32'h0);
      reset_i = 1'b1;
      tick();

      // 4 players: hits on 0, 2, 3 in separate cycles; only player 1 scores.
      bus_b.start_i = 1'b1;
      tick();
      chk("b_start_flags", 32'(flags_b()), 32'(F_PLAY));
      chk("b_start_rr",    32'(bus_b.round_reset_o), 32'h1);
      bus_b.start_i = 1'b0;
      bus_b.hit_i = 4'b0001;
      tick();
      chk("b_hit0_alive", 32'(bus_b.alive_o), 32'hE);
      chk("b_hit0_flags", 32'(flags_b()), 32'(F_PLAY));
      chk("b_hit0_rr",    32'(bus_b.round_reset_o), 32'h0);
      bus_b.hit_i = 4'b0101;
      tick();
      chk("b_hit2_alive", 32'(bus_b.alive_o), 32'hA);
      chk("b_hit2_flags", 32'(flags_b()), 32'(F_PLAY));
      bus_b.hit_i = 4'b1101;
      tick();
      chk("b_hit3_alive", 32'(bus_b.alive_o), 32'h2);
      chk("b_hit3_flags", 32'(flags_b()), 32'(F_CONT));
      chk("b_hit3_score", 32'(bus_b.score_o), 32'h000040);
      bus_b.hit_i = '0;
      repeat (3) tick();
      chk("b_pause_hold", 32'(flags_b()), 32'(F_CONT));
      tick();
      chk("b_pause_adv",  32'(flags_b()), 32'(F_PLAY));
      chk("b_pause_alive", 32'(bus_b.alive_o), 32'hF);
      chk("b_pause_rr",   32'(bus_b.round_reset_o), 32'h1);

      // 2 players: start from menu entry 0, target 5.
      bus_a.start_i = 1'b1;
      tick();
      chk("a_start_flags", 32'(flags_a()), 32'(F_PLAY));
      chk("a_start_rr",    32'(bus_a.round_reset_o), 32'h1);
      chk("a_start_score", 32'(bus_a.score_o), 32'h0);
      bus_a.start_i = 1'b0;
      tick();
      chk("a_rr_single",   32'(bus_a.round_reset_o), 32'h0);

      // Player 1 hit held for 10 cycles; auto-advance after 64 cycles in CONTINUE.
      bus_a.hit_i = 2'b10;
      tick();
      chk("a_hit1_score", 32'(bus_a.score_o), 32'h001);
      chk("a_hit1_alive", 32'(bus_a.alive_o), 32'h1);
      chk("a_hit1_flags", 32'(flags_a()), 32'(F_CONT));
      repeat (9) tick();
      bus_a.hit_i = '0;
      chk("a_held_score", 32'(bus_a.score_o), 32'h001);
      repeat (54) tick();
      chk("a_pause63",    32'(flags_a()), 32'(F_CONT));
      tick();
      chk("a_pause64",    32'(flags_a()), 32'(F_PLAY));
      chk("a_pause_alive", 32'(bus_a.alive_o), 32'h3);
      chk("a_pause_rr",   32'(bus_a.round_reset_o), 32'h1);
      tick();
      chk("a_pause_rr_off", 32'(bus_a.round_reset_o), 32'h0);

      // Simultaneous hits: draw.
      hit_a(2'b11);
      chk("a_draw_flags", 32'(flags_a()), 32'(F_CONT));
      chk("a_draw_score", 32'(bus_a.score_o), 32'h001);
      chk("a_draw_alive", 32'(bus_a.alive_o), 32'h0);
      bus_a.start_i = 1'b1;
      tick();
      chk("a_skip_flags", 32'(flags_a()), 32'(F_PLAY));
      chk("a_skip_rr",    32'(bus_a.round_reset_o), 32'h1);
      bus_a.start_i = 1'b0;
      tick();

      // Player 1 wins five rounds and the match.
      for (int i = 1; i <= 5; i++) begin
         hit_a(2'b01);
         if (i < 5) begin
            chk("a_p1_round", 32'(bus_a.score_o), 32'((i << 6) | 1));
            chk("a_p1_cont",  32'(flags_a()), 32'(F_CONT));
            skip_pause();
         end
      end
      chk("a_p1_final",  32'(flags_a()), 32'(F_FIN));
      chk("a_p1_winner", 32'(bus_a.winner_o), 32'h1);
      chk("a_p1_score",  32'(bus_a.score_o), 32'h141);
      hit_a(2'b10);
      chk("a_fin_hold",  32'(bus_a.score_o), 32'h141);
      bus_a.start_i = 1'b1;
      tick();
      chk("a_fin_menu",  32'(flags_a()), 32'(F_MENU));
      chk("a_fin_rr",    32'(bus_a.round_reset_o), 32'h0);
      bus_a.start_i = 1'b0;
      tick();

      // Menu navigation with wrap and simultaneous edges.
      bus_a.sel_up_i = 1'b1;
      tick();
      chk("a_up_wrap", 32'(bus_a.menu_sel_o), 32'h1);
      bus_a.sel_up_i = 1'b0;
      bus_a.sel_down_i = 1'b1;
      tick();
      chk("a_down_wrap", 32'(bus_a.menu_sel_o), 32'h0);
      bus_a.sel_down_i = 1'b0;
      tick();
      bus_a.sel_up_i = 1'b1;
      bus_a.sel_down_i = 1'b1;
      tick();
      chk("a_both", 32'(bus_a.menu_sel_o), 32'h0);
      bus_a.sel_up_i = 1'b0;
      bus_a.sel_down_i = 1'b0;
      tick();
      bus_a.sel_up_i = 1'b1;
      tick();
      chk("a_up_again", 32'(bus_a.menu_sel_o), 32'h1);
      bus_a.sel_up_i = 1'b0;
      tick();

      // Entry 1: target 10, player 0 wins ten rounds.
      bus_a.start_i = 1'b1;
      tick();
      chk("a_t10_score", 32'(bus_a.score_o), 32'h0);
      chk("a_t10_flags", 32'(flags_a()), 32'(F_PLAY));
      bus_a.start_i = 1'b0;
      tick();
      for (int i = 1; i <= 10; i++) begin
         hit_a(2'b10);
         if (i < 10) begin
            if (i == 9) begin
               chk("a_t10_nine",  32'(bus_a.score_o), 32'h009);
               chk("a_t10_ncont", 32'(flags_a()), 32'(F_CONT));
            end
            skip_pause();
         end
      end
      chk("a_t10_final",  32'(flags_a()), 32'(F_FIN));
      chk("a_t10_winner", 32'(bus_a.winner_o), 32'h0);
      chk("a_t10_sc",     32'(bus_a.score_o), 32'h00A);
      bus_a.start_i = 1'b1;
      tick();
      chk("a_t10_menu",   32'(flags_a()), 32'(F_MENU));
      chk("a_sel_kept",   32'(bus_a.menu_sel_o), 32'h1);
      bus_a.start_i = 1'b0;
      tick();

      // Asynchronous reset in the middle of a continue pause, score 3.
      skip_pause();
      for (int i = 1; i <= 3; i++) begin
         hit_a(2'b10);
         if (i < 3) skip_pause();
      end
      chk("a_pre_rst_score", 32'(bus_a.score_o), 32'h003);
      chk("a_pre_rst_flags", 32'(flags_a()), 32'(F_CONT));
      tick();
      #3;
      reset_i = 1'b0;
      #1;
      chk("a_arst_flags", 32'(flags_a()), 32'(F_MENU));
      chk("a_arst_score", 32'(bus_a.score_o), 32'h0);
      chk("a_arst_alive", 32'(bus_a.alive_o), 32'h3);
      chk("a_arst_sel",   32'(bus_a.menu_sel_o), 32'h0);
      chk("a_arst_rr",    32'(bus_a.round_reset_o), 32'h0);

      // Start held high across reset release gives an edge on the first clock.
      bus_a.start_i = 1'b1;
      #2;
      reset_i = 1'b1;
      tick();
      chk("a_held_start_flags", 32'(flags_a()), 32'(F_PLAY));
      chk("a_held_start_rr",    32'(bus_a.round_reset_o), 32'h1);
      bus_a.start_i = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter NUM_PLAYERS, default 2: number of tanks/players, legal range 2..8.
REQ-002 Parameter SCORE_BITS, default 6: width of each player's score counter.
REQ-003 Parameter WIN_SCORE, default 5: base points-to-win; WIN_SCORE*MENU_ITEMS SHALL fit in SCORE_BITS.
REQ-004 Parameter MENU_ITEMS, default 2: menu entries; entry k selects a target of WIN_SCORE*(k+1).
REQ-005 Parameter PAUSE_CYCLES, default 64: CONTINUE auto-advance delay in clk_i cycles, minimum 1.
REQ-006 clk_i  in  1  single system clock; all state on its rising edge.
REQ-007 reset_i  in  1  asynchronous, active-low reset.
REQ-008 start_i  in  1  level, shoot/space key; acts on rising edge only.
REQ-009 sel_up_i  in  1  level, menu up; acts on rising edge only.
REQ-010 sel_down_i  in  1  level, menu down; acts on rising edge only.
REQ-011 hit_i  in  NUM_PLAYERS  bit k = a bullet overlaps player k; may stay high many cycles.
REQ-012 score_o  out  NUM_PLAYERS*SCORE_BITS  packed scores; player k at bits [k*SCORE_BITS +: SCORE_BITS].
REQ-013 alive_o  out  NUM_PLAYERS  bit k = player k still alive this round.
REQ-014 winner_o  out  max(1,$clog2(NUM_PLAYERS))  index of the match winner; valid in FINAL only.
REQ-015 menu_sel_o  out  max(1,$clog2(MENU_ITEMS))  current menu entry.
REQ-016 is_menu_o / is_playing_o / is_continue_o / is_final_o  out  1 each  one-hot state flags.
REQ-017 round_reset_o  out  1  one-cycle pulse; clears map, tanks and bullets downstream.

Function
REQ-018 Edge detection: edge = input AND NOT registered previous value, for start_i, sel_up_i, sel_down_i and each hit_i bit; previous-value registers update every cycle.
REQ-019 All edge-triggered actions SHALL take effect on the same clock edge at which the edge is detected; outputs reflect them one cycle after the input rise is sampled.
REQ-020 States: MENU, PLAYING, CONTINUE, FINAL; exactly one is_*_o SHALL be high at all times.
REQ-021 MENU, sel_down edge: menu_sel increments, wrapping MENU_ITEMS-1 -> 0. MENU, sel_up edge: menu_sel decrements, wrapping 0 -> MENU_ITEMS-1. Simultaneous up and down edges: no change.
REQ-022 MENU, start edge: latch target = WIN_SCORE*(menu_sel+1); clear all scores; set alive to all ones; pulse round_reset_o; go to PLAYING.
REQ-023 Select edges SHALL be ignored outside MENU; hit edges SHALL be ignored outside PLAYING.
REQ-024 PLAYING: a hit edge on bit k clears alive[k]; multiple bits in one cycle all clear; a hit on an already-dead player has no effect.
REQ-025 PLAYING: when the updated alive vector has at most one bit set, the round ends on that same edge.
REQ-026 Round end with exactly one survivor j: score[j] increments, saturating at 2^SCORE_BITS-1.
REQ-027 Round end with zero survivors (simultaneous final hits): a draw; no score changes.
REQ-028 Round end: if the updated score[j] >= target, set winner = j and go to FINAL; otherwise go to CONTINUE and clear the pause counter.
REQ-029 CONTINUE: the pause counter increments each cycle. The state advances when the counter reaches PAUSE_CYCLES-1 or on a start edge, whichever comes first.
REQ-030 On CONTINUE advance: set alive to all ones, pulse round_reset_o, go to PLAYING.
REQ-031 FINAL: scores and winner hold; a start edge returns to MENU. menu_sel is retained; no round_reset_o pulse.
REQ-032 A start edge in PLAYING SHALL be ignored.
REQ-033 round_reset_o SHALL never be high for two consecutive cycles.

Reset
REQ-034 While reset_i = 0, immediately and regardless of clk_i: state = MENU (is_menu_o = 1, other flags 0), scores = 0, alive = all ones, winner = 0, menu_sel = 0, pause counter = 0, round_reset_o = 0, all edge-history registers = 0.
REQ-035 An input held high across reset deassertion SHALL produce an edge on the first clock after deassertion.
REQ-036 Reset mid-round or mid-pause SHALL abandon the match with no score update.

Verification
REQ-037 Start edge in MENU (menu_sel 0, NUM_PLAYERS 2): round_reset_o pulses 1 cycle, is_playing_o = 1, target 5, scores 0.
REQ-038 Hit edge on hit_i[1] held 10 cycles: score_o player 0 = 1, alive_o = 2'b01, is_continue_o = 1; after 64 cycles, PLAYING, alive_o = 2'b11, one round_reset_o pulse.
REQ-039 hit_i = 2'b11 in one cycle: draw, scores unchanged, CONTINUE entered.
REQ-040 MENU: sel_up edge from 0 -> menu_sel = 1. Start edge -> target 10. Player 0 wins 10 rounds -> FINAL, winner_o = 0, score_o player 0 = 10. Start edge -> MENU.
REQ-041 NUM_PLAYERS = 4: hits on players 0, 2, 3 in separate cycles -> only player 1 scores; the round ends on the third hit.
REQ-042 reset_i low mid-CONTINUE with a score of 3: all outputs take reset values asynchronously, before the next clk_i edge.
